// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DM_ADDRESS = 9;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DM_WORD_W  = DM_ADDRESS - 2;
  localparam int unsigned DM_DEPTH   = 1 << DM_WORD_W;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } dmem_state_t;

  typedef struct packed {
    logic                  we;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [2:0]            funct3;
  } dmem_req_t;

  // Byte-lane mask of an access before alignment to its byte offset.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   byte_mask = 4'b0001;
      2'b01:   byte_mask = 4'b0011;
      2'b10:   byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_load_ext.sv
// Load data alignment: byte shift of a two-word window plus sign/zero extension.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] word_lo,
  input  logic [DATA_W-1:0] word_hi,
  input  logic [1:0]        byte_off,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] win;

  assign win = 32'({word_hi, word_lo} >> {byte_off, 3'b000});

  always_comb begin
    rdata = win;
    case (funct3)
      F3_B:    rdata = {{24{win[7]}}, win[7:0]};
      F3_H:    rdata = {{16{win[15]}}, win[15:0]};
      F3_BU:   rdata = {24'h0, win[7:0]};
      F3_HU:   rdata = {16'h0, win[15:0]};
      default: rdata = win;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// RV32I byte-addressed data memory responder with single-cycle response pulse.
// Define DMEM_MISALIGN_EN to complete word-spanning accesses in two beats.
module dmem_responder
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  logic [DATA_W-1:0]    mem [DM_DEPTH];
  dmem_state_t          state, state_d;
  dmem_req_t            bus_req, cur;
  logic                 beat2;
  logic                 accept, legal, misaligned, err;
  logic [1:0]           off;
  logic [DM_WORD_W-1:0] wa;
  logic [7:0]           mask8;
  logic [63:0]          wd64;
  logic [3:0]           wr_mask;
  logic [DATA_W-1:0]    wr_data, mem_rd, ext_lo, ext_hi, ext_rdata;
  logic                 mem_we;
  logic                 rsp_valid_d, rsp_err_d, rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]    rsp_rdata_d, rsp_rdata_q;

  assign bus_req = {bus.req_we, bus.req_addr, bus.req_wdata, bus.req_funct3};

`ifdef DMEM_MISALIGN_EN
  dmem_req_t         req_q;
  logic [DATA_W-1:0] lo_q;
  logic              spans, capture;

  assign beat2  = (state == BEAT2);
  assign cur    = beat2 ? req_q : bus_req;
  assign spans  = |mask8[7:4];
  assign ext_lo = beat2 ? lo_q : mem_rd;
  assign err    = !legal;
`else
  assign beat2  = 1'b0;
  assign cur    = bus_req;
  assign ext_lo = mem_rd;
  assign err    = !legal || misaligned;
`endif

  assign bus.req_ready = (state == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // Access decode; in BEAT2 everything comes from the captured request.
  assign off        = cur.addr[1:0];
  assign wa         = cur.addr[DM_ADDRESS-1:2] + DM_WORD_W'(beat2);
  assign mask8      = {4'b0000, byte_mask(cur.funct3)} << off;
  assign wd64       = {32'h0, cur.wdata} << {off, 3'b000};
  assign legal      = cur.we ? (cur.funct3 inside {F3_B, F3_H, F3_W})
                             : (cur.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misaligned = ((cur.funct3[1:0] == 2'b01) && off[0]) ||
                      ((cur.funct3[1:0] == 2'b10) && (off != 2'b00));
  assign wr_mask    = beat2 ? mask8[7:4] : mask8[3:0];
  assign wr_data    = beat2 ? wd64[63:32] : wd64[31:0];
  assign mem_rd     = mem[wa];
  assign ext_hi     = beat2 ? mem_rd : '0;

  dmem_load_ext u_load_ext (
    .word_lo  (ext_lo),
    .word_hi  (ext_hi),
    .byte_off (off),
    .funct3   (cur.funct3),
    .rdata    (ext_rdata)
  );

  // Next state, memory write strobe and response payload.
  always_comb begin
    state_d     = state;
    mem_we      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef DMEM_MISALIGN_EN
    capture     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
`ifdef DMEM_MISALIGN_EN
          else if (spans) begin
            mem_we  = cur.we;
            capture = 1'b1;
            state_d = BEAT2;
          end
`endif
          else begin
            mem_we      = cur.we;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = cur.we ? '0 : ext_rdata;
          end
        end
      end
`ifdef DMEM_MISALIGN_EN
      BEAT2: begin
        mem_we      = cur.we && !reset;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = cur.we ? '0 : ext_rdata;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef DMEM_MISALIGN_EN
  // First-beat request and low word are held for the second beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
      lo_q  <= '0;
    end else if (capture) begin
      req_q <= bus_req;
      lo_q  <= mem_rd;
    end
  end
`endif

  // Storage is never reset; byte lanes are written individually.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[wa][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (honours DMEM_MISALIGN_EN).
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  dmem_responder_if bus ();

  dmem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request and collect the first response within a bounded window.
  task automatic do_req(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic v, output logic [31:0] rd,
                        output logic er, output int lat, output logic rdy1);
    int guard;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    bus.req_valid  = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rdy1 = bus.req_ready;
    v    = 1'b0;
    rd   = '0;
    er   = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 4; k++) begin
      if (bus.rsp_valid) begin
        v   = 1'b1;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready got %b exp 0", bus.req_ready);
    end
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'h0) begin
      tests_failed++;
      $display("FAIL reset_rsp got v=%b e=%b d=%h exp all 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_reset got %b exp 1", bus.req_ready);
    end
  endtask

  task automatic test_word();
    logic v, er, rdy1;
    logic [31:0] rd;
    int lat;
    do_req(1'b1, 9'h010, 32'hDEADBEEF, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'h0} || lat != 1) begin
      tests_failed++;
      $display("FAIL sw_rsp got v=%b e=%b d=%h lat=%0d exp v=1 e=0 d=0 lat=1", v, er, rd, lat);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsp_pulse_width got %b exp 0", bus.rsp_valid);
    end
    do_req(1'b0, 9'h010, 32'h0, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'hDEADBEEF} || lat != 1) begin
      tests_failed++;
      $display("FAIL lw_010 got v=%b e=%b d=%h lat=%0d exp d=deadbeef lat=1", v, er, rd, lat);
    end
  endtask

  task automatic test_subword();
    logic v, er, rdy1;
    logic [31:0] rd;
    int lat;
    do_req(1'b1, 9'h013, 32'h00000080, F3_B, v, rd, er, lat, rdy1);
    do_req(1'b0, 9'h013, 32'h0, F3_B, v, rd, er, lat, rdy1);
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'hFFFFFF80}) begin
      tests_failed++;
      $display("FAIL lb_013 got v=%b e=%b d=%h exp ffffff80", v, er, rd);
    end
    do_req(1'b0, 9'h013, 32'h0, F3_BU, v, rd, er, lat, rdy1);
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'h00000080}) begin
      tests_failed++;
      $display("FAIL lbu_013 got v=%b e=%b d=%h exp 00000080", v, er, rd);
    end
    do_req(1'b0, 9'h010, 32'h0, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'h80ADBEEF}) begin
      tests_failed++;
      $display("FAIL lw_after_sb got v=%b e=%b d=%h exp 80adbeef", v, er, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic v, er, rdy1;
    logic [31:0] rd;
    int lat;
    do_req(1'b1, 9'h014, 32'h11223344, F3_W, v, rd, er, lat, rdy1);
    @(negedge clk);
    bus.req_we     = 1'b0;
    bus.req_addr   = 9'h012;
    bus.req_funct3 = F3_H;
    bus.req_valid  = 1'b1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready0 got %b exp 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_addr   = 9'h014;
    bus.req_funct3 = F3_HU;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready1 got %b exp 1", bus.req_ready);
    end
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'hFFFF80AD}) begin
      tests_failed++;
      $display("FAIL b2b_lh got v=%b e=%b d=%h exp ffff80ad", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'h00003344}) begin
      tests_failed++;
      $display("FAIL b2b_lhu got v=%b e=%b d=%h exp 00003344", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle got %b exp 0", bus.rsp_valid);
    end
  endtask

  task automatic test_misaligned();
    logic v, er, rdy1;
    logic [31:0] rd;
    int lat;
    do_req(1'b0, 9'h012, 32'h0, F3_W, v, rd, er, lat, rdy1);
`ifdef DMEM_MISALIGN_EN
    tests_run++;
    if ({v, er, rd, rdy1} !== {1'b1, 1'b0, 32'h334480AD, 1'b0} || lat != 2) begin
      tests_failed++;
      $display("FAIL lw_012_split got v=%b e=%b d=%h rdy=%b lat=%0d exp d=334480ad rdy=0 lat=2",
               v, er, rd, rdy1, lat);
    end
`else
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b1, 32'h0} || lat != 1) begin
      tests_failed++;
      $display("FAIL lw_012_err got v=%b e=%b d=%h lat=%0d exp e=1 d=0 lat=1", v, er, rd, lat);
    end
`endif
    do_req(1'b0, 9'h011, 32'h0, F3_H, v, rd, er, lat, rdy1);
`ifdef DMEM_MISALIGN_EN
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'hFFFFADBE} || lat != 1) begin
      tests_failed++;
      $display("FAIL lh_011 got v=%b e=%b d=%h lat=%0d exp ffffadbe lat=1", v, er, rd, lat);
    end
`else
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL lh_011_err got v=%b e=%b d=%h exp e=1 d=0", v, er, rd);
    end
`endif
  endtask

  task automatic test_wrap();
    logic v, er, rdy1;
    logic [31:0] rd;
    int lat;
    do_req(1'b1, 9'h1FC, 32'h0, F3_W, v, rd, er, lat, rdy1);
    do_req(1'b1, 9'h000, 32'h0, F3_W, v, rd, er, lat, rdy1);
    do_req(1'b1, 9'h1FF, 32'h0000ABCD, F3_H, v, rd, er, lat, rdy1);
`ifdef DMEM_MISALIGN_EN
    tests_run++;
    if ({v, er, rdy1} !== 3'b100 || lat != 2) begin
      tests_failed++;
      $display("FAIL sh_1ff_rsp got v=%b e=%b rdy=%b lat=%0d exp v=1 e=0 rdy=0 lat=2", v, er, rdy1, lat);
    end
    do_req(1'b0, 9'h1FC, 32'h0, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if (rd !== 32'hCD000000) begin
      tests_failed++;
      $display("FAIL wrap_lo got %h exp cd000000", rd);
    end
    do_req(1'b0, 9'h000, 32'h0, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if (rd !== 32'h000000AB) begin
      tests_failed++;
      $display("FAIL wrap_hi got %h exp 000000ab", rd);
    end
    // Second pass: reset lands between the two beats.
    do_req(1'b1, 9'h1FC, 32'h0, F3_W, v, rd, er, lat, rdy1);
    do_req(1'b1, 9'h000, 32'h0, F3_W, v, rd, er, lat, rdy1);
    @(negedge clk);
    bus.req_we     = 1'b1;
    bus.req_addr   = 9'h1FF;
    bus.req_wdata  = 32'h00001234;
    bus.req_funct3 = F3_H;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    tests_run++;
    if (bus.req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL beat2_ready got %b exp 0", bus.req_ready);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_rsp got %b exp 0", bus.rsp_valid);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_rsp_late got %b exp 0", bus.rsp_valid);
    end
    do_req(1'b0, 9'h1FC, 32'h0, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if (rd !== 32'h34000000) begin
      tests_failed++;
      $display("FAIL abort_lo got %h exp 34000000", rd);
    end
    do_req(1'b0, 9'h000, 32'h0, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if (rd !== 32'h00000000) begin
      tests_failed++;
      $display("FAIL abort_hi got %h exp 00000000", rd);
    end
`else
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b1, 32'h0} || lat != 1) begin
      tests_failed++;
      $display("FAIL sh_1ff_err got v=%b e=%b d=%h lat=%0d exp e=1 lat=1", v, er, rd, lat);
    end
    do_req(1'b0, 9'h1FC, 32'h0, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL sh_1ff_nowrite_lo got %h exp 00000000", rd);
    end
    do_req(1'b0, 9'h000, 32'h0, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL sh_1ff_nowrite_hi got %h exp 00000000", rd);
    end
`endif
  endtask

  task automatic test_illegal();
    logic v, er, rdy1;
    logic [31:0] rd;
    int lat;
    do_req(1'b0, 9'h010, 32'h0, 3'b011, v, rd, er, lat, rdy1);
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL load_f3_011 got v=%b e=%b d=%h exp e=1 d=0", v, er, rd);
    end
    do_req(1'b1, 9'h010, 32'hFFFFFFFF, 3'b110, v, rd, er, lat, rdy1);
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL store_f3_110 got v=%b e=%b d=%h exp e=1 d=0", v, er, rd);
    end
    do_req(1'b0, 9'h010, 32'h0, F3_W, v, rd, er, lat, rdy1);
    tests_run++;
    if ({v, er, rd} !== {1'b1, 1'b0, 32'h80ADBEEF}) begin
      tests_failed++;
      $display("FAIL illegal_nowrite got v=%b e=%b d=%h exp 80adbeef", v, er, rd);
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    test_reset();
    test_word();
    test_subword();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
